// File: rtl/ysyx_220053_scoreboard_if.sv
// rtl/ysyx_220053_scoreboard_if.sv - issue/retire handshake bundle between ID/WB and the register scoreboard
interface ysyx_220053_scoreboard_if #(
  parameter int RIDX_W = 5,
  parameter int NWB    = 2
);
  logic                    iss_valid;
  logic                    iss_ready;
  logic [RIDX_W-1:0]       iss_rs1;
  logic                    iss_rs1_used;
  logic [RIDX_W-1:0]       iss_rs2;
  logic                    iss_rs2_used;
  logic [RIDX_W-1:0]       iss_rd;
  logic                    iss_wen;
  logic [NWB-1:0]          ret_valid;
  logic [NWB*RIDX_W-1:0]   ret_rd;

  modport master (
    output iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used, iss_rd, iss_wen,
    output ret_valid, ret_rd,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used, iss_rd, iss_wen,
    input  ret_valid, ret_rd,
    output iss_ready
  );
endinterface

// File: rtl/ysyx_220053_scoreboard.sv
// rtl/ysyx_220053_scoreboard.sv - per-GPR in-flight writer counters gating ID->EX issue
module ysyx_220053_scoreboard #(
  parameter int NREG         = 32,
  parameter int RIDX_W       = 5,
  parameter int CNT_W        = 2,
  parameter int NWB          = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter bit BYPASS       = 1'b1,
  parameter int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ysyx_220053_scoreboard_if.slave sb,
  output logic [NREG-1:0]        busy,
  output logic [INF_W-1:0]       inflight,
  output logic                   err
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0]  cnt     [NREG];
  logic [CNT_W-1:0]  cnt_nxt [NREG];
  int                dec     [NREG];
  int                dec_total;
  int                byp_total;
  logic [RIDX_W-1:0] ch_rd;
  logic              haz_rs1;
  logic              haz_rs2;
  logic              struct_stall;
  logic              ready;
  logic              fire_tracked;
  int                valid_dec;
  int                sum;
  int                net;
  int                inf_net;
  logic [INF_W-1:0]  inflight_nxt;
  logic              err_nxt;

  function automatic int byp(input int d);
    return BYPASS ? d : 0;
  endfunction

  // Retire decode and issue gating; never looks at iss_valid so ID sees no loop.
  always_comb begin
    ch_rd     = '0;
    dec_total = 0;
    for (int r = 0; r < NREG; r++) dec[r] = 0;
    for (int i = 0; i < NWB; i++) begin
      ch_rd = sb.ret_rd[i*RIDX_W +: RIDX_W];
      if (sb.ret_valid[i] && ch_rd != '0) begin
        dec[ch_rd] = dec[ch_rd] + 1;
        dec_total  = dec_total + 1;
      end
    end
    byp_total = BYPASS ? dec_total : 0;

    haz_rs1 = sb.iss_rs1_used && sb.iss_rs1 != '0 &&
              (int'(cnt[sb.iss_rs1]) - byp(dec[sb.iss_rs1])) > 0;
    haz_rs2 = sb.iss_rs2_used && sb.iss_rs2 != '0 &&
              (int'(cnt[sb.iss_rs2]) - byp(dec[sb.iss_rs2])) > 0;
    struct_stall = sb.iss_wen && sb.iss_rd != '0 &&
                   ((int'(cnt[sb.iss_rd]) - byp(dec[sb.iss_rd])) >= CNT_MAX ||
                    (int'(inflight) - byp_total) >= MAX_INFLIGHT);

    ready        = !rst && !flush && !(haz_rs1 || haz_rs2 || struct_stall);
    fire_tracked = sb.iss_valid && ready && sb.iss_wen && sb.iss_rd != '0;
  end

  assign sb.iss_ready = ready;

  // Net issue/retire per register; underflow clamps to zero and only the real decrement leaves inflight.
  always_comb begin
    err_nxt      = err;
    valid_dec    = 0;
    sum          = 0;
    net          = 0;
    inf_net      = 0;
    inflight_nxt = '0;
    for (int r = 0; r < NREG; r++) cnt_nxt[r] = '0;
    for (int r = 1; r < NREG; r++) begin
      sum = int'(cnt[r]) + ((fire_tracked && int'(sb.iss_rd) == r) ? 1 : 0);
      if (dec[r] > sum) begin
        valid_dec = valid_dec + sum;
        err_nxt   = 1'b1;
      end else begin
        valid_dec = valid_dec + dec[r];
        net       = sum - dec[r];
        if (net > CNT_MAX) begin
          cnt_nxt[r] = CNT_W'(CNT_MAX);
          err_nxt    = 1'b1;
        end else begin
          cnt_nxt[r] = CNT_W'(net);
        end
      end
    end
    inf_net = int'(inflight) + (fire_tracked ? 1 : 0) - valid_dec;
    if (inf_net > MAX_INFLIGHT) begin
      inflight_nxt = INF_W'(MAX_INFLIGHT);
      err_nxt      = 1'b1;
    end else if (inf_net < 0) begin
      inflight_nxt = '0;
    end else begin
      inflight_nxt = INF_W'(inf_net);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      inflight <= '0;
    end else begin
      cnt      <= cnt_nxt;
      inflight <= inflight_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) busy[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_ysyx_220053_scoreboard.sv
// tb/tb_ysyx_220053_scoreboard.sv - directed scoreboard bench driving a bypassing and a non-bypassing instance in lockstep
module tb_ysyx_220053_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       iss_valid, rs1_used, rs2_used, wen;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] ret_valid;
  logic [9:0] ret_rd;

  logic [31:0] busy_b, busy_n;
  logic [2:0]  inf_b, inf_n;
  logic        err_b, err_n;

  int errors  = 0;
  int checks  = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  ysyx_220053_scoreboard_if #(.RIDX_W(5), .NWB(2)) if_byp ();
  ysyx_220053_scoreboard_if #(.RIDX_W(5), .NWB(2)) if_nobyp ();

  assign if_byp.iss_valid      = iss_valid;
  assign if_byp.iss_rs1        = rs1;
  assign if_byp.iss_rs1_used   = rs1_used;
  assign if_byp.iss_rs2        = rs2;
  assign if_byp.iss_rs2_used   = rs2_used;
  assign if_byp.iss_rd         = rd;
  assign if_byp.iss_wen        = wen;
  assign if_byp.ret_valid      = ret_valid;
  assign if_byp.ret_rd         = ret_rd;
  assign if_nobyp.iss_valid    = iss_valid;
  assign if_nobyp.iss_rs1      = rs1;
  assign if_nobyp.iss_rs1_used = rs1_used;
  assign if_nobyp.iss_rs2      = rs2;
  assign if_nobyp.iss_rs2_used = rs2_used;
  assign if_nobyp.iss_rd       = rd;
  assign if_nobyp.iss_wen      = wen;
  assign if_nobyp.ret_valid    = ret_valid;
  assign if_nobyp.ret_rd       = ret_rd;

  ysyx_220053_scoreboard #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .flush(flush), .sb(if_byp.slave),
    .busy(busy_b), .inflight(inf_b), .err(err_b)
  );

  ysyx_220053_scoreboard #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .flush(flush), .sb(if_nobyp.slave),
    .busy(busy_n), .inflight(inf_n), .err(err_n)
  );

  // Reference state: index 0 = bypassing instance, 1 = non-bypassing.
  int m_cnt [2][32];
  int m_inf [2];
  bit m_err [2];

  typedef struct packed {
    logic        rdy_b, rdy_n;
    logic [31:0] busy_b, busy_n;
    logic [2:0]  inf_b, inf_n;
    logic        err_b, err_n;
  } exp_t;
  exp_t exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
      m_inf[b] = 0;
      m_err[b] = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_busy(input int b);
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < 32; r++) v[r] = (m_cnt[b][r] != 0);
    return v;
  endfunction

  task automatic model_step(input int b, output bit rdy);
    int dec [32];
    int tot, bd1, bd2, bdd, btot;
    bit h1, h2, st;
    logic [4:0] rr;
    for (int r = 0; r < 32; r++) dec[r] = 0;
    tot = 0;
    for (int i = 0; i < 2; i++) begin
      rr = ret_rd[i*5 +: 5];
      if (ret_valid[i] && rr != 0) begin
        dec[rr]++;
        tot++;
      end
    end
    bd1  = (b == 0) ? dec[rs1] : 0;
    bd2  = (b == 0) ? dec[rs2] : 0;
    bdd  = (b == 0) ? dec[rd]  : 0;
    btot = (b == 0) ? tot : 0;
    h1  = rs1_used && rs1 != 0 && (m_cnt[b][rs1] - bd1) > 0;
    h2  = rs2_used && rs2 != 0 && (m_cnt[b][rs2] - bd2) > 0;
    st  = wen && rd != 0 && ((m_cnt[b][rd] - bdd) >= 3 || (m_inf[b] - btot) >= 4);
    rdy = !flush && !h1 && !h2 && !st;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
      m_inf[b] = 0;
    end else begin
      if (iss_valid && rdy && wen && rd != 0) begin
        m_cnt[b][rd]++;
        m_inf[b]++;
      end
      for (int r = 1; r < 32; r++) begin
        if (dec[r] > m_cnt[b][r]) begin
          m_err[b]  = 1'b1;
          m_inf[b] -= m_cnt[b][r];
          m_cnt[b][r] = 0;
        end else begin
          m_cnt[b][r] -= dec[r];
          m_inf[b]    -= dec[r];
        end
      end
    end
  endtask

  // Entered just after a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [4:0] s1, input bit u1, input logic [4:0] s2,
                      input bit u2, input logic [4:0] d, input bit w, input logic [1:0] rv,
                      input logic [4:0] r0, input logic [4:0] r1, input bit fl);
    exp_t e;
    bit   rdy;
    logic act_rb, act_rn;
    step_no++;
    iss_valid = v; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
    rd = d; wen = w; ret_valid = rv; ret_rd = {r1, r0}; flush = fl;
    #1;
    model_step(0, rdy); e.rdy_b = rdy;
    model_step(1, rdy); e.rdy_n = rdy;
    e.busy_b = model_busy(0);    e.busy_n = model_busy(1);
    e.inf_b  = 3'(m_inf[0]);     e.inf_n  = 3'(m_inf[1]);
    e.err_b  = m_err[0];         e.err_n  = m_err[1];
    exp_q.push_back(e);
    act_rb = if_byp.iss_ready;
    act_rn = if_nobyp.iss_ready;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("ready_byp",    act_rb, e.rdy_b);
    check("ready_nobyp",  act_rn, e.rdy_n);
    check("busy_byp",     busy_b, e.busy_b);
    check("busy_nobyp",   busy_n, e.busy_n);
    check("inflight_byp", inf_b,  e.inf_b);
    check("inflight_nobyp", inf_n, e.inf_n);
    check("err_byp",      err_b,  e.err_b);
    check("err_nobyp",    err_n,  e.err_n);
    @(negedge clk);
  endtask

  task automatic iss_w(input logic [4:0] d);
    step(1, 5'd0, 0, 5'd0, 0, d, 1, 2'b00, 5'd0, 5'd0, 0);
  endtask

  task automatic do_flush();
    step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 5'd0, 5'd0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy_byp"},   busy_b, 32'd0);
    check({tag, "_busy_nobyp"}, busy_n, 32'd0);
    check({tag, "_inf_byp"},    inf_b,  3'd0);
    check({tag, "_inf_nobyp"},  inf_n,  3'd0);
    check({tag, "_err_byp"},    err_b,  1'b0);
    check({tag, "_err_nobyp"},  err_n,  1'b0);
    check({tag, "_rdy_byp"},    if_byp.iss_ready,   1'b0);
    check({tag, "_rdy_nobyp"},  if_nobyp.iss_ready, 1'b0);
  endtask

  initial begin
    model_clear();
    rst = 1'b1; flush = 1'b0;
    iss_valid = 1'b1; wen = 1'b1; rd = 5'd1;
    rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    ret_valid = 2'b00; ret_rd = '0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    check_reset_outputs("por_edge");
    rst = 1'b0;

    // RAW on x5: blocked until retire; same cycle with bypass, next cycle without
    iss_w(5'd5);
    step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 2'b00, 5'd0, 5'd0, 0);
    step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 2'b01, 5'd5, 5'd0, 0);
    step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 2'b00, 5'd0, 5'd0, 0);
    do_flush();

    // counter saturation on x7 and dual-channel retire of one register
    iss_w(5'd7);
    iss_w(5'd7);
    iss_w(5'd7);
    iss_w(5'd7);
    check("t2_busy7", busy_b[7], 1'b1);
    check("t2_inflight", inf_b, 3'd3);
    step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b11, 5'd7, 5'd7, 0);
    check("t2_inflight_after_retire", inf_b, 3'd1);
    do_flush();

    // global cap: fifth writer stalls, a non-writer still issues
    iss_w(5'd1);
    iss_w(5'd2);
    iss_w(5'd3);
    iss_w(5'd4);
    iss_w(5'd9);
    check("t3_inflight_cap", inf_b, 3'd4);
    step(1, 5'd10, 1, 5'd11, 1, 5'd9, 0, 2'b00, 5'd0, 5'd0, 0);
    step(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 2'b01, 5'd1, 5'd0, 0);
    do_flush();

    // x0 is never tracked nor a hazard, retiring it is harmless
    step(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 2'b01, 5'd0, 5'd0, 0);

    // issue+retire on the same register nets out; stray retire sets err
    iss_w(5'd3);
    step(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 2'b01, 5'd3, 5'd0, 0);
    step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b10, 5'd0, 5'd12, 0);
    check("t5_err", err_b, 1'b1);
    check("t5_inflight", inf_b, 3'd1);

    // flush wins over same-cycle retire and issue, err survives
    iss_w(5'd8);
    iss_w(5'd9);
    step(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 2'b01, 5'd3, 5'd0, 1);
    iss_w(5'd10);

    // asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    check_reset_outputs("async_edge");
    @(negedge clk);
    rst = 1'b0;
    iss_w(5'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
